// File: rtl/bin2bcd_if.sv
// Handshake and result bundle for bin2bcd_seq: a start/bin request in, and
// registered BCD digits, overflow, leading-zero mask and status out.
interface bin2bcd_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;
    logic [DIGITS-1:0]     blank;

    modport master (
        output start, bin,
        input  busy, done, bcd, overflow, blank
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, overflow, blank
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock.
// Optional BIN2BCD_BLANK_EN adds a leading-zero blanking mask on bus.blank.
module bin2bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic      clk,
    input  logic      rst_n,
    bin2bcd_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [SW-1:0]    scratch;
    logic [CW-1:0]    cnt;
    logic             ovf_sticky;
    logic [SW-1:0]    adj;
    logic [SW-1:0]    scratch_nxt;
    logic             ovf_nxt;
    logic             last_shift;
    logic [SW-1:0]    bcd_q;
    logic             ovf_q;

    // Add-3 on every digit >= 5, then one left shift of {scratch, shreg}.
    always_comb begin
        adj = scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
        end
        scratch_nxt = {adj[SW-2:0], shreg[WIDTH-1]};
        ovf_nxt     = ovf_sticky | adj[SW-1];
        last_shift  = (cnt == CW'(WIDTH - 1));
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: default assignment first so no path leaves state_nxt unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SHIFT;
            SHIFT:   if (last_shift) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state != IDLE);
        bus.done = (state == DONE);
    end

    // Results are captured on the final shift so they are valid for the
    // whole DONE cycle and never expose intermediate scratch values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg      <= '0;
            scratch    <= '0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    shreg      <= bus.bin;
                    scratch    <= '0;
                    cnt        <= '0;
                    ovf_sticky <= 1'b0;
                end
                SHIFT: begin
                    shreg      <= shreg << 1;
                    scratch    <= scratch_nxt;
                    ovf_sticky <= ovf_nxt;
                    cnt        <= cnt + CW'(1);
                    if (last_shift) begin
                        bcd_q <= scratch_nxt;
                        ovf_q <= ovf_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.bcd      = bcd_q;
    assign bus.overflow = ovf_q;

`ifdef BIN2BCD_BLANK_EN
    localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

    logic [DIGITS-1:0] blank_nxt;
    logic [DIGITS-1:0] blank_q;
    logic              all_zero;

    // Scan top-down: a digit is blank while it and everything above are zero.
    always_comb begin
        blank_nxt = '0;
        all_zero  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero     = all_zero & (scratch_nxt[4*i +: 4] == 4'd0);
            blank_nxt[i] = all_zero;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         blank_q <= BLANK_RST;
        else if (state == SHIFT && last_shift) blank_q <= blank_nxt;
    end

    assign bus.blank = blank_q;
`else
    assign bus.blank = '0;
`endif
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq: default 16-bit/5-digit
// instance plus a 10-bit/3-digit instance for overflow behaviour.
module tb_bin2bcd_seq;
`ifdef BIN2BCD_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    bin2bcd_if #(.WIDTH(16), .DIGITS(5)) bus ();
    bin2bcd_if #(.WIDTH(10), .DIGITS(3)) bus_s ();

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    bin2bcd_seq #(.WIDTH(10), .DIGITS(3)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(bus_s)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one rising edge, then count edges (acceptance edge = 1)
    // until done is seen, also counting cycles with busy high.
    task automatic run_big(input logic [15:0] value, output int lat, output int busy_cnt);
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = value;
        @(negedge clk);
        bus.start = 1'b0;
        lat      = 1;
        busy_cnt = bus.busy ? 1 : 0;
        while (!bus.done && lat < 100) begin
            @(negedge clk);
            lat++;
            if (bus.busy) busy_cnt++;
        end
    endtask

    task automatic run_small(input logic [9:0] value, output int lat);
        @(negedge clk);
        bus_s.start = 1'b1;
        bus_s.bin   = value;
        @(negedge clk);
        bus_s.start = 1'b0;
        lat = 1;
        while (!bus_s.done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.done) n++;
        end
    endtask

    initial begin
        int lat, busy_cnt, n_done;
        int done_at[$];

        bus.start   = 1'b0;
        bus.bin     = '0;
        bus_s.start = 1'b0;
        bus_s.bin   = '0;

        // Reset state
        #2;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_bcd", bus.bcd, 0);
        check("rst_ovf", bus.overflow, 0);
        check("rst_blank", bus.blank, BLANK_ON ? 5'b11110 : 5'b00000);
        check("rst_s_blank", bus_s.blank, BLANK_ON ? 3'b110 : 3'b000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Zero
        run_big(16'd0, lat, busy_cnt);
        check("zero_lat", lat, 17);
        check("zero_bcd", bus.bcd, 20'h00000);
        check("zero_ovf", bus.overflow, 0);
        check("zero_blank", bus.blank, BLANK_ON ? 5'b11110 : 5'b00000);

        // Full scale, busy length and single-cycle done
        run_big(16'd65535, lat, busy_cnt);
        check("max_lat", lat, 17);
        check("max_busy", busy_cnt, 17);
        check("max_bcd", bus.bcd, 20'h65535);
        check("max_ovf", bus.overflow, 0);
        check("max_blank", bus.blank, 5'b00000);
        @(negedge clk);
        check("max_done_1cyc", bus.done, 0);
        check("max_busy_low", bus.busy, 0);
        check("max_bcd_hold", bus.bcd, 20'h65535);

        // Start during SHIFT is ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 16'd1234;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_bcd_hold", bus.bcd, 20'h65535);
        bus.start = 1'b1;
        bus.bin   = 16'd9;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("mid_done_seen", (lat < 100), 1);
        check("mid_bcd", bus.bcd, 20'h01234);
        check("mid_blank", bus.blank, BLANK_ON ? 5'b10000 : 5'b00000);
        count_dones(30, n_done);
        check("mid_no_second_done", n_done, 0);

        // Asynchronous reset in the 8th SHIFT cycle
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 16'd4321;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_rst_busy", bus.busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check("mrst_busy", bus.busy, 0);
        check("mrst_done", bus.done, 0);
        check("mrst_bcd", bus.bcd, 0);
        check("mrst_ovf", bus.overflow, 0);
        check("mrst_blank", bus.blank, BLANK_ON ? 5'b11110 : 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;
        count_dones(30, n_done);
        check("mrst_no_done", n_done, 0);
        run_big(16'd77, lat, busy_cnt);
        check("after_rst_lat", lat, 17);
        check("after_rst_bcd", bus.bcd, 20'h00077);
        check("after_rst_blank", bus.blank, BLANK_ON ? 5'b11100 : 5'b00000);

        // Narrow instance: overflow boundary
        run_small(10'd1000, lat);
        check("s1000_lat", lat, 11);
        check("s1000_bcd", bus_s.bcd, 12'h000);
        check("s1000_ovf", bus_s.overflow, 1);
        check("s1000_blank", bus_s.blank, BLANK_ON ? 3'b110 : 3'b000);
        run_small(10'd999, lat);
        check("s999_bcd", bus_s.bcd, 12'h999);
        check("s999_ovf", bus_s.overflow, 0);
        check("s999_blank", bus_s.blank, 3'b000);

        // Start held high: back-to-back conversions 18 cycles apart
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 16'd42;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i == 39) bus.start = 1'b0;
            if (bus.done) begin
                done_at.push_back(i);
                check("b2b_bcd", bus.bcd, 20'h00042);
            end
        end
        check("b2b_count", done_at.size(), 3);
        if (done_at.size() == 3) begin
            check("b2b_first", done_at[0], 16);
            check("b2b_gap1", done_at[1] - done_at[0], 18);
            check("b2b_gap2", done_at[2] - done_at[1], 18);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
